// File: rtl/read_lcd.sv
// read_lcd: LCD read custom instruction.
// A read sets RS/RW, raises E after a setup time, captures DB7..DB0 at the
// end of the E pulse, then waits out a hold time. In poll mode the read repeats
// while the busy flag (bit7) stays set, up to MAX_POLLS reads.
module read_lcd #(
    parameter int unsigned T_SETUP   = 5,
    parameter int unsigned T_PULSE   = 25,
    parameter int unsigned T_HOLD    = 25,
    parameter int unsigned MAX_POLLS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [7:0]  data_in,
    output logic [31:0] result,
    output logic        done,
    output logic        register_select,
    output logic        read_write,
    output logic        enable_op
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    // Phase counter only has to reach the longest of the three phase lengths.
    localparam int unsigned T_SP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int unsigned T_MAX = (T_SP > T_HOLD) ? T_SP : T_HOLD;
    localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
    localparam logic [15:0]   POLL_LIMIT = 16'(MAX_POLLS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rdcnt_q, rdcnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          poll_q, poll_d;
    logic [31:0]   result_q, result_d;
    logic          done_q, done_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic          rw_q, rw_d;

    // Only bit 0 of each operand carries meaning.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{dataA[31:1], dataB[31:1]};

    // State and datapath registers; everything freezes while clk_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdcnt_q  <= '0;
            byte_q   <= '0;
            poll_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdcnt_q  <= rdcnt_d;
            byte_q   <= byte_d;
            poll_q   <= poll_d;
            result_q <= result_d;
            done_q   <= done_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            rw_q     <= rw_d;
        end
    end

    // Next-state and LCD bus sequencing for one read (or a chain of poll reads).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdcnt_d  = rdcnt_q;
        byte_d   = byte_q;
        poll_d   = poll_q;
        result_d = result_q;
        done_d   = 1'b0;
        e_d      = e_q;
        rs_d     = rs_q;
        rw_d     = rw_q;

        case (state_q)
            IDLE: begin
                e_d  = 1'b0;
                rw_d = 1'b0;
                if (start) begin
                    poll_d  = dataB[0];
                    rs_d    = dataB[0] ? 1'b0 : dataA[0];
                    rw_d    = 1'b1;
                    cnt_d   = '0;
                    rdcnt_d = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    e_d     = 1'b1;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    byte_d  = data_in;
                    if (rdcnt_q < POLL_LIMIT) begin
                        rdcnt_d = rdcnt_q + 16'd1;
                    end
                    e_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (poll_q && byte_q[7] && (rdcnt_q < POLL_LIMIT)) begin
                        cnt_d   = '0;
                        state_d = SETUP;
                    end else begin
                        result_d = {rdcnt_q, 7'b0, poll_q & byte_q[7], byte_q};
                        done_d   = 1'b1;
                        rw_d     = 1'b0;
                        rs_d     = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result          = result_q;
    assign done            = done_q;
    assign register_select = rs_q;
    assign read_write      = rw_q;
    assign enable_op       = e_q;

endmodule

// File: tb/tb_read_lcd.sv
// tb_read_lcd: directed stimulus with a scoreboard of expected completions.
// The stimulus pushes one expectation per accepted read; a negedge monitor
// checks E pulses, RS/RW, done width, latency and result against the head.
module tb_read_lcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic [7:0]  data_in = '0;
    logic [31:0] result;
    logic        done;
    logic        register_select;
    logic        read_write;
    logic        enable_op;

    read_lcd #(
        .MAX_POLLS(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_en          (clk_en),
        .start           (start),
        .dataA           (dataA),
        .dataB           (dataB),
        .data_in         (data_in),
        .result          (result),
        .done            (done),
        .register_select (register_select),
        .read_write      (read_write),
        .enable_op       (enable_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int unsigned pulses;
        int unsigned lat;
        int unsigned dwidth;
        logic        rs;
        int unsigned ewidth;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input int unsigned pulses,
                                input int unsigned lat, input int unsigned dwidth,
                                input logic rs, input int unsigned ewidth);
        exp_t e;
        e.res    = res;
        e.pulses = pulses;
        e.lat    = lat;
        e.dwidth = dwidth;
        e.rs     = rs;
        e.ewidth = ewidth;
        e.acc    = 0;
        return e;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    int unsigned e_run = 0;
    int unsigned e_pulses = 0;
    int unsigned d_run = 0;
    int unsigned last_dw = 1;
    int unsigned done_seen = 0;
    logic        prev_e = 1'b0;
    logic        prev_d = 1'b0;

    always @(negedge clk) begin
        exp_t cur;
        if (reset) begin
            sb.delete();
            e_run    = 0;
            e_pulses = 0;
            d_run    = 0;
            prev_e   = 1'b0;
            prev_d   = 1'b0;
        end else begin
            if (enable_op && !prev_e) begin
                e_pulses++;
                if (sb.size() > 0) begin
                    check("rs_during_read", register_select, sb[0].rs);
                    check("rw_during_read", read_write, 1);
                end else begin
                    check("e_without_txn", 32'(sb.size()), 1);
                end
            end
            if (enable_op) begin
                e_run++;
            end else if (prev_e) begin
                if (sb.size() > 0) check("e_width", e_run, sb[0].ewidth);
                e_run = 0;
            end

            if (done && !prev_d) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(sb.size()), 1);
                end else begin
                    cur = sb.pop_front();
                    check("result", result, cur.res);
                    check("e_pulses", e_pulses, cur.pulses);
                    check("latency", cyc - cur.acc, cur.lat);
                    check("rw_at_done", read_write, 0);
                    check("rs_at_done", register_select, 0);
                    last_dw = cur.dwidth;
                end
                e_pulses = 0;
            end
            if (done) begin
                d_run++;
            end else if (prev_d) begin
                check("done_width", d_run, last_dw);
                d_run = 0;
            end
            prev_e = enable_op;
            prev_d = done;
        end
    end

    // Issue a one-cycle start and register its expectation; returns accept edge.
    task automatic go(input logic [31:0] a, input logic [31:0] b, input exp_t e,
                      output int unsigned acc);
        dataA = a;
        dataB = b;
        start = 1'b1;
        e.acc = cyc + 1;
        acc   = e.acc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        dataA = a;
        dataB = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_e(input logic lvl, input int unsigned budget, input string name);
        int unsigned n = 0;
        while (enable_op !== lvl && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, enable_op, lvl);
    endtask

    task automatic wait_drain(input int unsigned budget, input string name);
        int unsigned n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(sb.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        int unsigned d0;

        // Reset dominates clk_en and start.
        reset  = 1'b1;
        clk_en = 1'b0;
        start  = 1'b1;
        dataA  = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 0);
        check("reset_done", done, 0);
        check("reset_e", enable_op, 0);
        check("reset_rs", register_select, 0);
        check("reset_rw", read_write, 0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        clk_en = 1'b1;
        @(posedge clk); #1;

        // Single data-RAM read.
        data_in = 8'h5A;
        go(32'h1, 32'h0, mk(32'h0001_005A, 1, 55, 1, 1'b1, 25), acc);
        wait_drain(100, "drain_single");

        // Non-poll read with bit7 set: no timeout flag, count 1; result holds meanwhile.
        data_in = 8'hC3;
        go(32'h0, 32'h0, mk(32'h0001_00C3, 1, 55, 1, 1'b0, 25), acc);
        repeat (20) @(posedge clk);
        #1;
        check("result_hold", result, 32'h0001_005A);
        wait_drain(100, "drain_nonpoll_bit7");

        // Busy-flag poll clears on the third read; RS forced to 0.
        data_in = 8'h80;
        go(32'h1, 32'h1, mk(32'h0003_0023, 3, 165, 1, 1'b0, 25), acc);
        wait_e(1'b1, 100, "poll_e1_rise");
        wait_e(1'b0, 100, "poll_e1_fall");
        wait_e(1'b1, 100, "poll_e2_rise");
        wait_e(1'b0, 100, "poll_e2_fall");
        data_in = 8'h23;
        wait_drain(200, "drain_poll_clear");

        // Poll whose first read is already clear.
        data_in = 8'h7F;
        go(32'h0, 32'h1, mk(32'h0001_007F, 1, 55, 1, 1'b0, 25), acc);
        wait_drain(100, "drain_poll_first_clear");

        // Poll timeout at MAX_POLLS=4.
        data_in = 8'h8F;
        d0 = done_seen;
        go(32'h0, 32'h1, mk(32'h0004_018F, 4, 220, 1, 1'b0, 25), acc);
        wait_drain(300, "drain_poll_timeout");
        repeat (60) @(posedge clk);
        #1;
        check("timeout_done_count", done_seen - d0, 1);

        // clk_en toggling every cycle doubles every phase.
        data_in = 8'h5A;
        go(32'h1, 32'h0, mk(32'h0001_005A, 1, 110, 2, 1'b1, 50), acc);
        clk_en = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            clk_en = ~clk_en;
        end
        clk_en = 1'b1;
        wait_drain(100, "drain_clk_en_toggle");

        // Starts during SETUP, HOLD and on the done edge are all ignored.
        data_in = 8'h11;
        d0 = done_seen;
        go(32'h1, 32'h0, mk(32'h0001_0011, 1, 55, 1, 1'b1, 25), acc);
        wait_until(acc + 2);
        pulse_start(32'h0, 32'h1);
        wait_until(acc + 40);
        pulse_start(32'h0, 32'h1);
        wait_until(acc + 54);
        pulse_start(32'h0, 32'h1);
        wait_drain(100, "drain_busy_start");
        repeat (80) @(posedge clk);
        #1;
        check("busy_done_count", done_seen - d0, 1);

        // Reset mid-PULSE aborts the read without a done.
        data_in = 8'h5A;
        d0 = done_seen;
        go(32'h1, 32'h0, mk(32'h0001_005A, 1, 55, 1, 1'b1, 25), acc);
        wait_e(1'b1, 100, "abort_e_rise");
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_e", enable_op, 0);
        check("abort_rw", read_write, 0);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("abort_no_done", done_seen - d0, 0);

        // A fresh read after the abort completes normally.
        data_in = 8'h3C;
        go(32'h1, 32'h0, mk(32'h0001_003C, 1, 55, 1, 1'b1, 25), acc);
        wait_drain(100, "drain_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
